// File: rtl/lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_pkg : shared constants for the lfsr_gen pseudo-random source    |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
package lfsr_pkg;

   // Default feedback masks for common widths (bit i => state[i] feeds back)
   localparam logic [7:0]  TAP_MASK_W8  = 8'hB8;
   localparam logic [15:0] TAP_MASK_W16 = 16'h9021;
   localparam logic [31:0] TAP_MASK_W32 = 32'h8020_0003;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } lfsr_state_e;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_step : combinational STEPS-fold Fibonacci LFSR shift            |
// | Rev 1.0   : initial release                                          |
// +----------------------------------------------------------------------+
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] TAP_MASK = TAP_MASK_W16,
   parameter int               STEPS    = 1
) (
   input  logic [WIDTH-1:0] s_i,
   output logic [WIDTH-1:0] s_o
);

   always_comb begin
      s_o = s_i;
      for (int k = 0; k < STEPS; k++) begin
         s_o = {s_o[WIDTH-2:0], ^(s_o & TAP_MASK)};
      end
   end

endmodule : lfsr_step
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_gen : Fibonacci LFSR word source with valid/ready handshake,    |
// |            zero-seed substitution and lock-up recovery.              |
// |            LFSR_PERIOD_CNT_EN adds period_cnt / period_hit outputs.  |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH         = 16,
   parameter logic [WIDTH-1:0] TAP_MASK      = TAP_MASK_W16,
   parameter int               STEPS         = 1,
   parameter logic [WIDTH-1:0] FALLBACK_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] seed,
   input  logic             load,
   input  logic             en,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] lfsr_out,
   output logic             seed_err,
   output logic             lockup
`ifdef LFSR_PERIOD_CNT_EN
   ,
   output logic [WIDTH:0]   period_cnt,
   output logic             period_hit
`endif
);

   lfsr_state_e      state_q;
   logic             valid_q;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic             lockup_q, lockup_d;
   logic             seed_err_q, seed_err_d;

   logic             w_seed_zero;
   logic [WIDTH-1:0] w_seed_fix;
   logic             w_adv;
   logic [WIDTH-1:0] w_step;

   assign w_seed_zero = (seed == '0);
   assign w_seed_fix  = w_seed_zero ? FALLBACK_SEED : seed;
   // A load consumes a concurrent handshake without advancing
   assign w_adv       = (state_q == ST_RUN) && valid_q && out_ready && !load;

   lfsr_step #(
      .WIDTH    (WIDTH),
      .TAP_MASK (TAP_MASK),
      .STEPS    (STEPS)
   ) u_step (
      .s_i (lfsr_q),
      .s_o (w_step)
   );

   always_comb begin
      lfsr_d     = lfsr_q;
      lockup_d   = lockup_q;
      seed_err_d = 1'b0;
      if (load) begin
         lfsr_d     = w_seed_fix;
         lockup_d   = 1'b0;
         seed_err_d = w_seed_zero;
      end else if (w_adv) begin
         if (w_step == '0) begin
            lfsr_d   = FALLBACK_SEED;
            lockup_d = 1'b1;
         end else begin
            lfsr_d   = w_step;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         lfsr_q     <= w_seed_fix;
         seed_err_q <= w_seed_zero;
         lockup_q   <= 1'b0;
      end else begin
         lfsr_q     <= lfsr_d;
         seed_err_q <= seed_err_d;
         lockup_q   <= lockup_d;
      end
   end

   // Handshake FSM; out_valid is registered alongside the state
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  state_q <= ST_RUN;
                  valid_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!en) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = valid_q;
   assign lfsr_out  = lfsr_q;
   assign seed_err  = seed_err_q;
   assign lockup    = lockup_q;

`ifdef LFSR_PERIOD_CNT_EN
   logic [WIDTH:0]   cnt_q;
   logic [WIDTH-1:0] seed_copy_q;
   logic             hit_q;

   always_ff @(posedge clk) begin
      if (!resetn || load) begin
         cnt_q       <= '0;
         seed_copy_q <= w_seed_fix;
         hit_q       <= 1'b0;
      end else if (w_adv) begin
         cnt_q       <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
         hit_q       <= (lfsr_d == seed_copy_q);
      end else begin
         hit_q       <= 1'b0;
      end
   end

   assign period_cnt = cnt_q;
   assign period_hit = hit_q;
`endif

endmodule : lfsr_gen
`default_nettype wire
